// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control sequencer: opcodes, state
// register values, datapath select encodings and the bundled control word.
package mips_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'd0;
   localparam logic [5:0] OP_J     = 6'd2;
   localparam logic [5:0] OP_BEQ   = 6'd4;
   localparam logic [5:0] OP_ADDI  = 6'd8;
   localparam logic [5:0] OP_LW    = 6'd35;
   localparam logic [5:0] OP_SW    = 6'd43;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_ADDIEX = 4'd9,
      S_ADDIWB = 4'd10,
      S_JUMP   = 4'd11
   } state_e;

   typedef enum logic [1:0] {
      SRCB_B       = 2'b00,
      SRCB_FOUR    = 2'b01,
      SRCB_IMM     = 2'b10,
      SRCB_IMM_SH2 = 2'b11
   } alu_src_b_e;

   typedef enum logic [1:0] {
      ALU_ADD   = 2'b00,
      ALU_SUB   = 2'b01,
      ALU_FUNCT = 2'b10,
      ALU_RSVD  = 2'b11
   } alu_op_e;

   typedef enum logic [1:0] {
      PC_ALU    = 2'b00,
      PC_ALUOUT = 2'b01,
      PC_JUMP   = 2'b10,
      PC_RSVD   = 2'b11
   } pc_src_e;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mem_to_reg;
      logic       reg_dst;
      logic       reg_write;
      logic       alu_src_a;
      alu_src_b_e alu_src_b;
      alu_op_e    alu_op;
      pc_src_e    pc_src;
      logic       retire;
      logic       illegal_op;
   } ctrl_t;

   function automatic logic is_supported(input logic [5:0] op);
      case (op)
         OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: return 1'b1;
         default:                                       return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the sequencer (master) and the multi-cycle datapath
// (slave): opcode and memory handshake in, mux selects and write-enables out.
interface multicycle_control_fsm_if;

   logic [5:0] op;
   logic       mem_ready;
   logic       pc_write;
   logic       pc_write_cond;
   logic       iord;
   logic       mem_read;
   logic       mem_write;
   logic       ir_write;
   logic       mem_to_reg;
   logic       reg_dst;
   logic       reg_write;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [1:0] alu_op;
   logic [1:0] pc_src;
   logic       retire;
   logic       illegal_op;
   logic       mem_error;
   logic [3:0] state_dbg;

   modport master (
      input  op, mem_ready,
      output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
             mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
             pc_src, retire, illegal_op, mem_error, state_dbg
   );

   modport slave (
      output op, mem_ready,
      input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
             mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
             pc_src, retire, illegal_op, mem_error, state_dbg
   );

endinterface

// File: rtl/mem_wait_timer.sv
// Counts consecutive not-ready cycles of a memory access and flags a timeout
// on the MEM_TIMEOUT-th one; MEM_TIMEOUT=0 disables the timeout.
module mem_wait_timer #(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic waiting,
   input  logic ready,
   output logic timeout
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_LAST =
      CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

   logic [CNT_W-1:0] cnt;

   // cnt holds the not-ready cycles already seen, so the current cycle is the
   // MEM_TIMEOUT-th one when cnt reaches MEM_TIMEOUT-1; ready always wins.
   assign timeout = (MEM_TIMEOUT != 0) && waiting && !ready && (cnt >= CNT_LAST);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (!waiting || ready || timeout) begin
         cnt <= '0;
      end else if (cnt != CNT_MAX) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Moore sequencer for the multi-cycle MIPS datapath: walks fetch/decode/
// execute/memory/writeback per opcode, stalling on mem_ready with timeout.
module multicycle_control_fsm
   import mips_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 15,
   parameter int CNT_W       = 4
) (
   input logic                    clk,
   input logic                    rst,
   multicycle_control_fsm_if.master bus
);

   state_e state;
   state_e state_next;
   ctrl_t  ctrl;
   ctrl_t  ctrl_out;
   logic   waiting;
   logic   timeout;
   logic   mem_error_q;

   assign waiting = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);

   mem_wait_timer #(
      .MEM_TIMEOUT (MEM_TIMEOUT),
      .CNT_W       (CNT_W)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .waiting (waiting),
      .ready   (bus.mem_ready),
      .timeout (timeout)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_FETCH;
         mem_error_q <= 1'b0;
      end else begin
         state       <= state_next;
         mem_error_q <= timeout;
      end
   end

   // NOTE: every output of this block gets a default first so no path through
   // the case statement can leave a signal unassigned and infer a latch.
   always_comb begin
      ctrl       = '0;
      state_next = state;
      case (state)
         S_FETCH: begin
            ctrl.mem_read  = 1'b1;
            ctrl.alu_src_b = SRCB_FOUR;
            ctrl.ir_write  = bus.mem_ready;
            ctrl.pc_write  = bus.mem_ready;
            if (bus.mem_ready)  state_next = S_DECODE;
            else if (timeout)   state_next = S_FETCH;
         end
         S_DECODE: begin
            ctrl.alu_src_b  = SRCB_IMM_SH2;
            ctrl.illegal_op = !is_supported(bus.op);
            case (bus.op)
               OP_LW, OP_SW: state_next = S_MEMADR;
               OP_RTYPE:     state_next = S_EXEC;
               OP_BEQ:       state_next = S_BRANCH;
               OP_ADDI:      state_next = S_ADDIEX;
               OP_J:         state_next = S_JUMP;
               default:      state_next = S_FETCH;
            endcase
         end
         S_MEMADR: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            state_next     = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            ctrl.mem_read = 1'b1;
            ctrl.iord     = 1'b1;
            if (bus.mem_ready)  state_next = S_MEMWB;
            else if (timeout)   state_next = S_FETCH;
         end
         S_MEMWB: begin
            ctrl.reg_write  = 1'b1;
            ctrl.mem_to_reg = 1'b1;
            ctrl.retire     = 1'b1;
            state_next      = S_FETCH;
         end
         S_MEMWR: begin
            ctrl.mem_write = 1'b1;
            ctrl.iord      = 1'b1;
            ctrl.retire    = bus.mem_ready;
            if (bus.mem_ready || timeout) state_next = S_FETCH;
         end
         S_EXEC: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_op    = ALU_FUNCT;
            state_next     = S_ALUWB;
         end
         S_ALUWB: begin
            ctrl.reg_write = 1'b1;
            ctrl.reg_dst   = 1'b1;
            ctrl.retire    = 1'b1;
            state_next     = S_FETCH;
         end
         S_BRANCH: begin
            ctrl.alu_src_a     = 1'b1;
            ctrl.alu_op        = ALU_SUB;
            ctrl.pc_write_cond = 1'b1;
            ctrl.pc_src        = PC_ALUOUT;
            ctrl.retire        = 1'b1;
            state_next         = S_FETCH;
         end
         S_ADDIEX: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            state_next     = S_ADDIWB;
         end
         S_ADDIWB: begin
            ctrl.reg_write = 1'b1;
            ctrl.retire    = 1'b1;
            state_next     = S_FETCH;
         end
         S_JUMP: begin
            ctrl.pc_write = 1'b1;
            ctrl.pc_src   = PC_JUMP;
            ctrl.retire   = 1'b1;
            state_next    = S_FETCH;
         end
         default: state_next = S_FETCH;
      endcase
   end

   // Outputs are forced low while rst is high, whatever state the register holds.
   assign ctrl_out = rst ? '0 : ctrl;

   assign bus.pc_write      = ctrl_out.pc_write;
   assign bus.pc_write_cond = ctrl_out.pc_write_cond;
   assign bus.iord          = ctrl_out.iord;
   assign bus.mem_read      = ctrl_out.mem_read;
   assign bus.mem_write     = ctrl_out.mem_write;
   assign bus.ir_write      = ctrl_out.ir_write;
   assign bus.mem_to_reg    = ctrl_out.mem_to_reg;
   assign bus.reg_dst       = ctrl_out.reg_dst;
   assign bus.reg_write     = ctrl_out.reg_write;
   assign bus.alu_src_a     = ctrl_out.alu_src_a;
   assign bus.alu_src_b     = ctrl_out.alu_src_b;
   assign bus.alu_op        = ctrl_out.alu_op;
   assign bus.pc_src        = ctrl_out.pc_src;
   assign bus.retire        = ctrl_out.retire;
   assign bus.illegal_op    = ctrl_out.illegal_op;
   assign bus.mem_error     = mem_error_q && !rst;
   assign bus.state_dbg     = rst ? 4'd0 : state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: a per-cycle vector table for the
// instruction flows plus hand-written timeout and mid-wait reset sequences.
module tb_multicycle_control_fsm;

   // Control word layout: pw pwc iord mrd mwr irw m2r rdst rw asa asb[2] aop[2] psrc[2] ret ill merr
   localparam logic [18:0] C_ZERO      = 19'b0_0_0_0_0_0_0_0_0_0_00_00_00_0_0_0;
   localparam logic [18:0] C_F_RDY     = 19'b1_0_0_1_0_1_0_0_0_0_01_00_00_0_0_0;
   localparam logic [18:0] C_F_WAIT    = 19'b0_0_0_1_0_0_0_0_0_0_01_00_00_0_0_0;
   localparam logic [18:0] C_DEC       = 19'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_0_0;
   localparam logic [18:0] C_DEC_ILL   = 19'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_1_0;
   localparam logic [18:0] C_MEMADR    = 19'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0_0;
   localparam logic [18:0] C_MEMRD     = 19'b0_0_1_1_0_0_0_0_0_0_00_00_00_0_0_0;
   localparam logic [18:0] C_MEMWB     = 19'b0_0_0_0_0_0_1_0_1_0_00_00_00_1_0_0;
   localparam logic [18:0] C_MEMWR_RDY = 19'b0_0_1_0_1_0_0_0_0_0_00_00_00_1_0_0;
   localparam logic [18:0] C_EXEC      = 19'b0_0_0_0_0_0_0_0_0_1_00_10_00_0_0_0;
   localparam logic [18:0] C_ALUWB     = 19'b0_0_0_0_0_0_0_1_1_0_00_00_00_1_0_0;
   localparam logic [18:0] C_BRANCH    = 19'b0_1_0_0_0_0_0_0_0_1_00_01_01_1_0_0;
   localparam logic [18:0] C_ADDIEX    = 19'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0_0;
   localparam logic [18:0] C_ADDIWB    = 19'b0_0_0_0_0_0_0_0_1_0_00_00_00_1_0_0;
   localparam logic [18:0] C_JUMP      = 19'b1_0_0_0_0_0_0_0_0_0_00_00_10_1_0_0;

   localparam logic [3:0] ST_FETCH = 4'd0, ST_DECODE = 4'd1, ST_MEMADR = 4'd2,
                          ST_MEMRD = 4'd3, ST_MEMWB = 4'd4, ST_MEMWR = 4'd5,
                          ST_EXEC = 4'd6, ST_ALUWB = 4'd7, ST_BRANCH = 4'd8,
                          ST_ADDIEX = 4'd9, ST_ADDIWB = 4'd10, ST_JUMP = 4'd11;

   typedef struct {
      logic        rst;
      logic [5:0]  op;
      logic        rdy;
      logic [3:0]  st;
      logic [18:0] ctrl;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;
   vec_t vecs[$];

   multicycle_control_fsm_if bus ();

   multicycle_control_fsm #(
      .MEM_TIMEOUT (15),
      .CNT_W       (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   logic [18:0] act_ctrl;
   assign act_ctrl = {bus.pc_write, bus.pc_write_cond, bus.iord, bus.mem_read,
                      bus.mem_write, bus.ir_write, bus.mem_to_reg, bus.reg_dst,
                      bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                      bus.pc_src, bus.retire, bus.illegal_op, bus.mem_error};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_all(input string name, input logic [3:0] st, input logic [18:0] c);
      check({name, ".state"}, 32'(bus.state_dbg), 32'(st));
      check({name, ".ctrl"},  32'(act_ctrl),      32'(c));
   endtask

   // Drive inputs just after a falling edge; outputs settle before the next rising edge.
   task automatic apply(input logic r, input logic [5:0] o, input logic d);
      rst           = r;
      bus.op        = o;
      bus.mem_ready = d;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst           = 1'b1;
      bus.op        = 6'd0;
      bus.mem_ready = 1'b0;

      // reset, then R-type
      vecs.push_back(vec_t'{1'b1, 6'd0,  1'b1, ST_FETCH,  C_ZERO});
      vecs.push_back(vec_t'{1'b0, 6'd0,  1'b1, ST_FETCH,  C_F_RDY});
      vecs.push_back(vec_t'{1'b0, 6'd0,  1'b1, ST_DECODE, C_DEC});
      vecs.push_back(vec_t'{1'b0, 6'd0,  1'b1, ST_EXEC,   C_EXEC});
      vecs.push_back(vec_t'{1'b0, 6'd0,  1'b1, ST_ALUWB,  C_ALUWB});
      // lw with three wait cycles in MEMRD
      vecs.push_back(vec_t'{1'b0, 6'd35, 1'b1, ST_FETCH,  C_F_RDY});
      vecs.push_back(vec_t'{1'b0, 6'd35, 1'b1, ST_DECODE, C_DEC});
      vecs.push_back(vec_t'{1'b0, 6'd35, 1'b1, ST_MEMADR, C_MEMADR});
      vecs.push_back(vec_t'{1'b0, 6'd35, 1'b0, ST_MEMRD,  C_MEMRD});
      vecs.push_back(vec_t'{1'b0, 6'd35, 1'b0, ST_MEMRD,  C_MEMRD});
      vecs.push_back(vec_t'{1'b0, 6'd35, 1'b0, ST_MEMRD,  C_MEMRD});
      vecs.push_back(vec_t'{1'b0, 6'd35, 1'b1, ST_MEMRD,  C_MEMRD});
      vecs.push_back(vec_t'{1'b0, 6'd35, 1'b1, ST_MEMWB,  C_MEMWB});
      // sw
      vecs.push_back(vec_t'{1'b0, 6'd43, 1'b1, ST_FETCH,  C_F_RDY});
      vecs.push_back(vec_t'{1'b0, 6'd43, 1'b1, ST_DECODE, C_DEC});
      vecs.push_back(vec_t'{1'b0, 6'd43, 1'b1, ST_MEMADR, C_MEMADR});
      vecs.push_back(vec_t'{1'b0, 6'd43, 1'b1, ST_MEMWR,  C_MEMWR_RDY});
      // beq
      vecs.push_back(vec_t'{1'b0, 6'd4,  1'b1, ST_FETCH,  C_F_RDY});
      vecs.push_back(vec_t'{1'b0, 6'd4,  1'b1, ST_DECODE, C_DEC});
      vecs.push_back(vec_t'{1'b0, 6'd4,  1'b1, ST_BRANCH, C_BRANCH});
      // addi, with one fetch wait
      vecs.push_back(vec_t'{1'b0, 6'd8,  1'b0, ST_FETCH,  C_F_WAIT});
      vecs.push_back(vec_t'{1'b0, 6'd8,  1'b1, ST_FETCH,  C_F_RDY});
      vecs.push_back(vec_t'{1'b0, 6'd8,  1'b1, ST_DECODE, C_DEC});
      vecs.push_back(vec_t'{1'b0, 6'd8,  1'b1, ST_ADDIEX, C_ADDIEX});
      vecs.push_back(vec_t'{1'b0, 6'd8,  1'b1, ST_ADDIWB, C_ADDIWB});
      // illegal opcode returns to FETCH
      vecs.push_back(vec_t'{1'b0, 6'd63, 1'b1, ST_FETCH,  C_F_RDY});
      vecs.push_back(vec_t'{1'b0, 6'd63, 1'b1, ST_DECODE, C_DEC_ILL});
      vecs.push_back(vec_t'{1'b0, 6'd63, 1'b0, ST_FETCH,  C_F_WAIT});

      @(posedge clk);
      @(negedge clk);
      foreach (vecs[i]) begin
         apply(vecs[i].rst, vecs[i].op, vecs[i].rdy);
         check_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].ctrl);
         tick();
      end

      // sw timing out in MEMWR after 15 not-ready cycles
      apply(1'b0, 6'd43, 1'b1); check_all("to_fetch", ST_FETCH, C_F_RDY); tick();
      apply(1'b0, 6'd43, 1'b1); check_all("to_dec", ST_DECODE, C_DEC); tick();
      apply(1'b0, 6'd43, 1'b1); check_all("to_madr", ST_MEMADR, C_MEMADR); tick();
      for (int i = 1; i <= 15; i++) begin
         apply(1'b0, 6'd43, 1'b0);
         check($sformatf("to_wr%0d.state", i), 32'(bus.state_dbg), 32'(ST_MEMWR));
         check($sformatf("to_wr%0d.retire", i), 32'(bus.retire), 32'd0);
         check($sformatf("to_wr%0d.mem_err", i), 32'(bus.mem_error), 32'd0);
         tick();
      end
      apply(1'b0, 6'd43, 1'b1);
      check("to_abort.state", 32'(bus.state_dbg), 32'(ST_FETCH));
      check("to_abort.mem_error", 32'(bus.mem_error), 32'd1);
      tick();
      apply(1'b0, 6'd43, 1'b1);
      check_all("to_pulse_end", ST_DECODE, C_DEC);
      tick();

      // same access, mem_ready arrives on the 15th cycle
      apply(1'b0, 6'd43, 1'b1); check_all("late_madr", ST_MEMADR, C_MEMADR); tick();
      for (int i = 1; i <= 14; i++) begin
         apply(1'b0, 6'd43, 1'b0);
         check($sformatf("late_wr%0d.state", i), 32'(bus.state_dbg), 32'(ST_MEMWR));
         tick();
      end
      apply(1'b0, 6'd43, 1'b1);
      check_all("late_complete", ST_MEMWR, C_MEMWR_RDY);
      tick();

      // fetch timeout refetches with a mem_error pulse
      for (int i = 1; i <= 15; i++) begin
         apply(1'b0, 6'd35, 1'b0);
         check_all($sformatf("fto%0d", i), ST_FETCH, C_F_WAIT);
         tick();
      end
      apply(1'b0, 6'd35, 1'b1);
      check_all("fto_refetch", ST_FETCH, C_F_RDY | 19'd1);
      tick();

      // reset in the middle of a lw memory wait, then j
      apply(1'b0, 6'd35, 1'b1); check_all("rst_dec", ST_DECODE, C_DEC); tick();
      apply(1'b0, 6'd35, 1'b1); check_all("rst_madr", ST_MEMADR, C_MEMADR); tick();
      apply(1'b0, 6'd35, 1'b0); check_all("rst_wait1", ST_MEMRD, C_MEMRD); tick();
      apply(1'b0, 6'd35, 1'b0); check_all("rst_wait2", ST_MEMRD, C_MEMRD); tick();
      apply(1'b1, 6'd35, 1'b1); check_all("rst_held", ST_FETCH, C_ZERO); tick();
      apply(1'b0, 6'd2,  1'b1); check_all("j_fetch", ST_FETCH, C_F_RDY); tick();
      apply(1'b0, 6'd2,  1'b1); check_all("j_dec", ST_DECODE, C_DEC); tick();
      apply(1'b0, 6'd2,  1'b1); check_all("j_jump", ST_JUMP, C_JUMP); tick();
      apply(1'b0, 6'd2,  1'b0); check_all("j_next", ST_FETCH, C_F_WAIT);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Moore-style sequencer for the multi-cycle MIPS datapath: one shared ALU, one unified instruction/data memory, and IR/MDR/A/B/ALUOut holding registers.
- Decodes the opcode held in IR and steps the datapath through fetch, decode, execute, memory and writeback states.
- Stalls on a memory ready handshake and recovers from memory timeouts.
- Sits between the IR opcode field and every datapath mux select and write-enable.

Parameters:
- MEM_TIMEOUT, 15, consecutive not-ready cycles tolerated in a memory state before abort; 0 disables the timeout.
- CNT_W, 4, wait-counter width; must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- op  in  6  IR[31:26], valid from DECODE onward.
- mem_ready  in  1  memory access completes in this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load qualified by ALU zero (beq).
- iord  out  1  memory address select: 0=PC, 1=ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- ir_write  out  1  IR load.
- mem_to_reg  out  1  writeback select: 0=ALUOut, 1=MDR.
- reg_dst  out  1  destination select: 0=rt, 1=rd.
- reg_write  out  1  register file write.
- alu_src_a  out  1  ALU A select: 0=PC, 1=A.
- alu_src_b  out  2  ALU B select: 00=B, 01=const 4, 10=signext imm, 11=signext imm<<2.
- alu_op  out  2  00=add, 01=sub, 10=funct-decoded.
- pc_src  out  2  PC source: 00=ALU result, 01=ALUOut, 10=jump target.
- retire  out  1  one-cycle pulse when an instruction completes.
- illegal_op  out  1  asserted in DECODE for an unsupported opcode.
- mem_error  out  1  registered one-cycle pulse after a memory timeout.
- state_dbg  out  4  current state encoding.

Behaviour:
- Supported opcodes: R=0, j=2, beq=4, addi=8, lw=35, sw=43.
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP.
- Reset: while rst=1 every output is 0. On the next edge the state is FETCH, the wait counter is 0 and mem_error is 0. A reset during any state, including a memory wait, abandons the instruction with no write-enable asserted.
- Any output not listed for a state is 0.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00. ir_write and pc_write are asserted only in the cycle mem_ready=1 (combinational gating); the FSM then moves to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (precompute branch target). Next state by op: lw/sw -> MEMADR, R -> EXEC, beq -> BRANCH, addi -> ADDIEX, j -> JUMP. Any other op: illegal_op=1, next state FETCH, no register or memory write; PC stays at PC+4.
- MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00. Next: lw -> MEMRD, sw -> MEMWR.
- MEMRD: mem_read=1, iord=1. Advances to MEMWB on mem_ready.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1, retire=1.
- MEMWR: mem_write=1, iord=1. retire=1 in the mem_ready cycle, then FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_op=10.
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0, retire=1.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_src=01, retire=1.
- ADDIEX: alu_src_a=1, alu_src_b=10, alu_op=00.
- ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0, retire=1.
- JUMP: pc_write=1, pc_src=10, retire=1.
- Writeback, BRANCH and JUMP states return to FETCH.
- Zero-wait latency (cycles, FETCH to retire inclusive): lw 5, sw 4, R 4, addi 4, beq 3, j 3.
- Wait counter:
  - Increments each cycle in FETCH, MEMRD or MEMWR while mem_ready=0.
  - Clears on mem_ready=1 and on any state change.
  - When the count reaches MEM_TIMEOUT with mem_ready still 0, next state is FETCH and mem_error pulses in the following cycle.
  - No retire, no register/memory write and no PC write for the aborted access; a FETCH timeout refetches the same PC.
  - mem_ready=1 in the same cycle the timeout would fire takes priority: the access completes normally.
  - The counter saturates and never wraps.

Decomposition:
- Package mips_ctrl_pkg: opcode constants, state enum, alu_src_b, alu_op and pc_src encodings.
- Sub-module mem_wait_timer (params MEM_TIMEOUT, CNT_W): inputs clk, rst, waiting, ready; output timeout.
- The FSM next-state logic and output decode stay in multicycle_control_fsm.

Test Plan:
- Reset then R (op=0), mem_ready always 1: states FETCH, DECODE, EXEC, ALUWB; ir_write=1 in cycle 1; reg_write=1 and reg_dst=1 in cycle 4; retire in cycle 4 only.
- lw (op=35) with mem_ready low for 3 cycles in MEMRD: MEMRD held 4 cycles; MEMWB follows with mem_to_reg=1; retire at cycle 8.
- sw (op=43), then beq (op=4): mem_write=1 with iord=1 for exactly 1 cycle; BRANCH asserts pc_write_cond=1, pc_src=01, alu_op=01.
- Illegal op=63: illegal_op=1 in DECODE, next FETCH; no reg_write, mem_write or retire.
- MEM_TIMEOUT=15, mem_ready stuck 0 in MEMWR: 15 cycles in MEMWR, then FETCH; mem_error pulses 1 cycle; no mem_write completion or retire. Repeat with mem_ready=1 on the 15th cycle: normal completion, no mem_error.
- rst asserted mid-MEMRD wait, then j (op=2): all outputs 0 during rst, state FETCH afterwards; j completes in 3 cycles with pc_src=10 and pc_write=1.
